// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// operand_fetch: register status table and operand resolution for issue.
// Optional macro CDB_BYPASS_EN forwards same-cycle CDB data instead of stalling.
// Revision: 1.0
// ============================================================================
module operand_fetch #(
    parameter int WIDTH    = 16,
    parameter int TAG_BITS = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [WIDTH-1:0]    R1,
    input  logic [WIDTH-1:0]    R2,
    input  logic [WIDTH-1:0]    R3,
    input  logic [WIDTH-1:0]    R4,
    input  logic [WIDTH-1:0]    R5,
    input  logic [WIDTH-1:0]    R6,
    input  logic [WIDTH-1:0]    R7,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [2:0]          iss_rs,
    input  logic [2:0]          iss_rt,
    input  logic [2:0]          iss_rd,
    input  logic [TAG_BITS-1:0] iss_tag,
    input  logic                cdb_valid,
    input  logic [TAG_BITS-1:0] cdb_tag,
    input  logic [WIDTH-1:0]    cdb_data,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [WIDTH-1:0]    op_vj,
    output logic [WIDTH-1:0]    op_vk,
    output logic [TAG_BITS-1:0] op_qj,
    output logic [TAG_BITS-1:0] op_qk,
    output logic [WIDTH-1:0]    data,
    output logic [2:0]          address,
    output logic                write
);

    localparam int NREGS = 8;

    logic [TAG_BITS-1:0] qi_q [1:NREGS-1];
    logic [TAG_BITS-1:0] qi_d [1:NREGS-1];
    logic                op_valid_q, op_valid_d;
    logic [WIDTH-1:0]    op_vj_q, op_vj_d;
    logic [WIDTH-1:0]    op_vk_q, op_vk_d;
    logic [TAG_BITS-1:0] op_qj_q, op_qj_d;
    logic [TAG_BITS-1:0] op_qk_q, op_qk_d;

    logic [WIDTH-1:0]    w_bank [NREGS];
    logic [TAG_BITS-1:0] w_qi   [NREGS];
    logic [NREGS-1:0]    w_match;
    logic                w_cdb_hit;
    logic [2:0]          w_cdb_addr;
    logic [2:0]          w_src  [2];
    logic [WIDTH-1:0]    w_v    [2];
    logic [TAG_BITS-1:0] w_q    [2];
    logic                w_hazard_stall;
    logic                w_accept;

    // Index 0 is a hard-wired zero register with no status entry.
    always_comb begin
        w_bank[0] = '0;
        w_bank[1] = R1;
        w_bank[2] = R2;
        w_bank[3] = R3;
        w_bank[4] = R4;
        w_bank[5] = R5;
        w_bank[6] = R6;
        w_bank[7] = R7;
        w_qi[0]   = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_qi[r] = qi_q[r];
        end
    end

    // Descending scan so the lowest matching register drives the write port.
    always_comb begin
        w_match    = '0;
        w_cdb_hit  = 1'b0;
        w_cdb_addr = 3'd0;
        for (int r = NREGS - 1; r >= 1; r--) begin
            if (cdb_valid && (cdb_tag != '0) && (w_qi[r] == cdb_tag)) begin
                w_match[r] = 1'b1;
                w_cdb_hit  = 1'b1;
                w_cdb_addr = 3'(r);
            end
        end
    end

    assign write   = w_cdb_hit;
    assign address = w_cdb_addr;
    assign data    = w_cdb_hit ? cdb_data : '0;

    always_comb begin
        w_src[0] = iss_rs;
        w_src[1] = iss_rt;
        for (int s = 0; s < 2; s++) begin
            w_v[s] = '0;
            w_q[s] = '0;
            if (w_src[s] != 3'd0) begin
                if (w_qi[w_src[s]] == '0) begin
                    w_v[s] = w_bank[w_src[s]];
`ifdef CDB_BYPASS_EN
                end else if (w_match[w_src[s]]) begin
                    w_v[s] = cdb_data;
`endif
                end else begin
                    w_q[s] = w_qi[w_src[s]];
                end
            end
        end
    end

`ifdef CDB_BYPASS_EN
    assign w_hazard_stall = 1'b0;
`else
    // A source waiting on the tag broadcast this cycle is re-read from the bank next cycle.
    assign w_hazard_stall = w_match[iss_rs] | w_match[iss_rt];
`endif

    assign iss_ready = (~op_valid_q | op_ready) & ~w_hazard_stall;
    assign w_accept  = iss_valid & iss_ready;

    // A new producer for rd overrides a same-cycle CDB clear of rd.
    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            qi_d[r] = qi_q[r];
            if (w_match[r]) begin
                qi_d[r] = '0;
            end
            if (w_accept && (iss_rd == 3'(r))) begin
                qi_d[r] = iss_tag;
            end
        end
    end

    always_comb begin
        op_valid_d = op_valid_q;
        op_vj_d    = op_vj_q;
        op_vk_d    = op_vk_q;
        op_qj_d    = op_qj_q;
        op_qk_d    = op_qk_q;
        if (w_accept) begin
            op_valid_d = 1'b1;
            op_vj_d    = w_v[0];
            op_vk_d    = w_v[1];
            op_qj_d    = w_q[0];
            op_qk_d    = w_q[1];
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < NREGS; r++) begin
                qi_q[r] <= '0;
            end
            op_valid_q <= 1'b0;
            op_vj_q    <= '0;
            op_vk_q    <= '0;
            op_qj_q    <= '0;
            op_qk_q    <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                qi_q[r] <= qi_d[r];
            end
            op_valid_q <= op_valid_d;
            op_vj_q    <= op_vj_d;
            op_vk_q    <= op_vk_d;
            op_qj_q    <= op_qj_d;
            op_qk_q    <= op_qk_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_vj    = op_vj_q;
    assign op_vk    = op_vk_q;
    assign op_qj    = op_qj_q;
    assign op_qk    = op_qk_q;

endmodule
`default_nettype wire
